xc_sha256_msched: RTL and testbench

XC_SHA256_MSCHED -- requirements
Module: xc_sha256_msched

---
 rtl/xc_sha256_pkg.sv | 28 ++
 rtl/xc_sha256_sigma.sv | 15 +
 rtl/xc_sha256_msched.sv | 117 +++++++++++
 tb/tb_xc_sha256_msched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xc_sha256_pkg.sv
// Shared SHA-256 helpers: rotate/shift primitives, message-schedule sigmas,
// the schedule FSM state type and the block length.
package xc_sha256_pkg;

  localparam int SHA256_MSG_WORDS = 16;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } msched_state_e;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] shr32(input logic [31:0] x, input int unsigned n);
    return x >> n;
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return ror32(x, 7) ^ ror32(x, 18) ^ shr32(x, 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return ror32(x, 17) ^ ror32(x, 19) ^ shr32(x, 10);
  endfunction

endpackage

// File: rtl/xc_sha256_sigma.sv
// Combinational message-schedule sigma pair (s0, s1), reusable by the
// schedule datapath and by checkers.
module xc_sha256_sigma
  import xc_sha256_pkg::*;
(
  input  logic [31:0] s0_x,
  input  logic [31:0] s1_x,
  output logic [31:0] s0,
  output logic [31:0] s1
);

  assign s0 = sigma0(s0_x);
  assign s1 = sigma1(s1_x);

endmodule

// File: rtl/xc_sha256_msched.sv
// SHA-256 message schedule: loads 16 words into a sliding window, then emits
// W[0..ROUNDS-1]. Optional LOAD passthrough: XC_SHA256_MSCHED_PASSTHRU_EN.
module xc_sha256_msched
  import xc_sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_idx,
  output logic        out_last
);

`ifdef XC_SHA256_MSCHED_PASSTHRU_EN
  localparam bit PT = 1'b1;
`else
  localparam bit PT = 1'b0;
`endif
  // In passthrough the load phase already emitted W[0..15]; RUN resumes at 16.
  localparam logic [5:0] T_RUN0   = PT ? 6'(SHA256_MSG_WORDS) : 6'd0;
  localparam logic [5:0] T_LAST   = 6'(ROUNDS - 1);
  localparam bit         PT_SHORT = PT && (ROUNDS == SHA256_MSG_WORDS);

  msched_state_e state, state_nxt;
  logic [3:0]  ld_cnt, ld_nxt;
  logic [5:0]  t, t_nxt;
  logic [SHA256_MSG_WORDS-1:0][31:0] w;
  logic [31:0] w_in, w_next, sig0, sig1;
  logic        shift;

  xc_sha256_sigma u_sigma (
    .s0_x (w[1]),
    .s1_x (w[14]),
    .s0   (sig0),
    .s1   (sig1)
  );

  assign w_next = sig1 + w[9] + sig0 + w[0];

  always_comb begin
    state_nxt = state;
    ld_nxt    = ld_cnt;
    t_nxt     = t;
    shift     = 1'b0;
    w_in      = in_data;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = w[0];
    out_idx   = t;
    out_last  = 1'b0;
    case (state)
      LOAD: begin
`ifdef XC_SHA256_MSCHED_PASSTHRU_EN
        in_ready  = out_ready;
        out_valid = in_valid;
        out_data  = in_data;
        out_idx   = {2'b00, ld_cnt};
        out_last  = PT_SHORT && (ld_cnt == 4'd15);
`else
        in_ready  = 1'b1;
`endif
        if (in_valid && in_ready) begin
          shift  = 1'b1;
          ld_nxt = ld_cnt + 4'd1;
          if (ld_cnt == 4'd15) begin
            t_nxt     = PT_SHORT ? 6'd0 : T_RUN0;
            state_nxt = PT_SHORT ? LOAD : RUN;
          end
        end
      end
      RUN: begin
        out_valid = 1'b1;
        // Passthrough keeps W[t-16..t-1] in the window, so W[t] is the new word.
        out_data  = PT ? w_next : w[0];
        out_last  = (t == T_LAST);
        if (out_ready) begin
          shift = 1'b1;
          w_in  = w_next;
          if (t == T_LAST) begin
            state_nxt = LOAD;
            t_nxt     = 6'd0;
            ld_nxt    = 4'd0;
          end else begin
            t_nxt = t + 6'd1;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state  <= LOAD;
      ld_cnt <= 4'd0;
      t      <= 6'd0;
      w      <= '0;
    end else if (flush) begin
      state  <= LOAD;
      ld_cnt <= 4'd0;
      t      <= 6'd0;
    end else begin
      state  <= state_nxt;
      ld_cnt <= ld_nxt;
      t      <= t_nxt;
      if (shift) w <= {w_in, w[SHA256_MSG_WORDS-1:1]};
    end
  end

endmodule

// File: tb/tb_xc_sha256_msched.sv
// Scoreboard bench for xc_sha256_msched: directed blocks, stalls, flush, reset, ROUNDS=16.
module tb_xc_sha256_msched;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] in_data = '0;

  logic        a_in_ready, a_out_valid, a_out_last;
  logic [31:0] a_out_data;
  logic [5:0]  a_out_idx;
  logic        b_in_ready, b_out_valid, b_out_last;
  logic [31:0] b_out_data;
  logic [5:0]  b_out_idx;

  logic        m_in_ready, m_out_valid, m_out_last;
  logic [31:0] m_out_data;
  logic [5:0]  m_out_idx;

  always #5 g_clk = ~g_clk;

  xc_sha256_msched #(.ROUNDS(64)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready & ~sel),
    .out_data(a_out_data), .out_idx(a_out_idx), .out_last(a_out_last)
  );

  xc_sha256_msched #(.ROUNDS(16)) dut16 (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready & sel),
    .out_data(b_out_data), .out_idx(b_out_idx), .out_last(b_out_last)
  );

  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_out_data  = sel ? b_out_data  : a_out_data;
  assign m_out_idx   = sel ? b_out_idx   : a_out_idx;
  assign m_out_last  = sel ? b_out_last  : a_out_last;

  typedef struct packed {
    logic [31:0] d;
    logic [5:0]  i;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  int          n_run = 0;
  int          n_fail = 0;
  logic [31:0] blk[16];
  logic [31:0] ew[64];
  bit          abc_chk = 0;

  function automatic logic [31:0] bs0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] bs1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic push_exp(input int n, input int rounds);
    exp_t e;
    for (int t = 0; t < 16; t++) ew[t] = blk[t];
    for (int t = 16; t < 64; t++) ew[t] = bs1(ew[t-2]) + ew[t-7] + bs0(ew[t-15]) + ew[t-16];
    for (int t = 0; t < n; t++) begin
      e.d = ew[t];
      e.i = 6'(t);
      e.l = (t == rounds - 1);
      sb.push_back(e);
    end
  endtask

  task automatic load_blk(input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = blk[i];
      k = 0;
      while (!m_in_ready && k < 100) begin
        tick();
        k++;
      end
      if (k == 100) begin
        n_run++;
        n_fail++;
        $display("FAIL load_wait: in_ready low for %0d cycles, required high", k);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd, output int cyc);
    cyc = 0;
    while (sb.size() != 0 && cyc < 1000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    chk("drain_done", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  initial begin : mon
    exp_t        e;
    logic        stl;
    logic [38:0] held;
    stl  = 1'b0;
    held = '0;
    forever begin
      @(negedge g_clk);
      if (g_reset || flush) begin
        stl = 1'b0;
      end else begin
        if (stl) begin
          chk("stall_valid", 64'(m_out_valid), 64'd1);
          chk("stall_hold", 64'({m_out_data, m_out_idx, m_out_last}), 64'(held));
        end
        if (m_out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL unexpected_out: idx %0d data 0x%0h, required no output", m_out_idx, m_out_data);
          end else begin
            e = sb.pop_front();
            chk("out_data", 64'(m_out_data), 64'(e.d));
            chk("out_idx", 64'(m_out_idx), 64'(e.i));
            chk("out_last", 64'(m_out_last), 64'(e.l));
            if (abc_chk && m_out_idx == 6'd16) chk("abc_w16", 64'(m_out_data), 64'h61626380);
            if (abc_chk && m_out_idx == 6'd17) chk("abc_w17", 64'(m_out_data), 64'h000F0000);
          end
        end
        stl  = m_out_valid && !out_ready;
        held = {m_out_data, m_out_idx, m_out_last};
      end
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, 64'(a_in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(a_out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(a_out_data), 64'd0);
    chk({tag, "_out_idx"}, 64'(a_out_idx), 64'd0);
    chk({tag, "_out_last"}, 64'(a_out_last), 64'd0);
  endtask

  initial begin
    int cyc;
    int k;
    repeat (2) tick();
    chk_reset_outs("rst");
    g_reset = 1'b0;
    tick();

    // "abc" block, full-rate drain
    set_abc();
    abc_chk = 1;
    push_exp(64, 64);
    load_blk(16);
    chk("first_valid", 64'(m_out_valid), 64'd1);
    drain(0, cyc);
    chk("idle_in_ready", 64'(m_in_ready), 64'd1);
    chk("idle_out_valid", 64'(m_out_valid), 64'd0);
    abc_chk = 0;

    // all-zero block: 64 words with no gaps
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    push_exp(64, 64);
    load_blk(16);
    drain(0, cyc);
    chk("zero_no_gaps", 64'(cyc), 64'd64);

    // "abc" with random back-pressure
    set_abc();
    abc_chk = 1;
    push_exp(64, 64);
    load_blk(16);
    drain(1, cyc);

    // flush at t=20, then a fresh block
    set_abc();
    push_exp(20, 64);
    load_blk(16);
    k = 0;
    while (m_out_idx != 6'd20 && k < 100) begin
      tick();
      k++;
    end
    chk("reach_t20", 64'(m_out_idx), 64'd20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", 64'(m_out_valid), 64'd0);
    chk("flush_in_ready", 64'(m_in_ready), 64'd1);
    chk("flush_sb_empty", 64'(sb.size()), 64'd0);
    push_exp(64, 64);
    load_blk(16);
    drain(0, cyc);

    // reset after 7 loaded words
    for (int i = 0; i < 16; i++) blk[i] = 32'(32'h9E3779B9 * (i + 1));
    load_blk(7);
    g_reset = 1'b1;
    #1;
    chk_reset_outs("midrst");
    tick();
    g_reset = 1'b0;
    tick();
    set_abc();
    push_exp(64, 64);
    load_blk(16);
    drain(0, cyc);
    abc_chk = 0;

    // ROUNDS=16 instance: W[0..15] = M[0..15]
    sel = 1'b1;
    for (int i = 0; i < 16; i++) blk[i] = 32'(32'h9E3779B9 * (i + 1)) ^ 32'h5A5A0000;
    push_exp(16, 16);
    load_blk(16);
    drain(0, cyc);
    chk("r16_cycles", 64'(cyc), 64'd16);
    chk("r16_idle", 64'(m_out_valid), 64'd0);
    sel = 1'b0;

    tick();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
